// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between the fetch and data requesters.
// Locks the grant until the address is taken and routes each response back by an in-order source tag.
module sram_like_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,

    input  logic                                 inst_req,
    input  logic                                 inst_wr,
    input  logic [1:0]                           inst_size,
    input  logic [3:0]                           inst_wstrb,
    input  logic [31:0]                          inst_addr,
    input  logic [31:0]                          inst_wdata,
    output logic                                 inst_addr_ok,
    output logic                                 inst_data_ok,
    output logic [31:0]                          inst_rdata,

    input  logic                                 data_req,
    input  logic                                 data_wr,
    input  logic [1:0]                           data_size,
    input  logic [3:0]                           data_wstrb,
    input  logic [31:0]                          data_addr,
    input  logic [31:0]                          data_wdata,
    output logic                                 data_addr_ok,
    output logic                                 data_data_ok,
    output logic [31:0]                          data_rdata,

    output logic                                 mem_req,
    output logic                                 mem_wr,
    output logic [1:0]                           mem_size,
    output logic [3:0]                           mem_wstrb,
    output logic [31:0]                          mem_addr,
    output logic [31:0]                          mem_wdata,
    input  logic                                 mem_addr_ok,
    input  logic                                 mem_data_ok,
    input  logic [31:0]                          mem_rdata,

    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
    output logic                                 protocol_err
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_INST = 2'd1,
        HOLD_DATA = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic                        last_grant_q;      // 0 = inst, 1 = data
    logic [MAX_OUTSTANDING-1:0]  tag_fifo;
    logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]            count_q;
    logic                        protocol_err_q;

    logic fifo_full, fifo_empty, arb_en;
    logic grant_inst, grant_data;
    logic accept, pop, head_tag;

    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    assign arb_en     = !reset && !fifo_full;

    // Grant selection: round-robin only on a fresh tie, otherwise the lock holds
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (arb_en) begin
            case (state_q)
                IDLE: begin
                    if (inst_req && data_req) begin
                        if (last_grant_q) grant_inst = 1'b1;
                        else              grant_data = 1'b1;
                    end else if (inst_req) begin
                        grant_inst = 1'b1;
                    end else if (data_req) begin
                        grant_data = 1'b1;
                    end
                end
                HOLD_INST: grant_inst = 1'b1;
                HOLD_DATA: grant_data = 1'b1;
                default: ;
            endcase
        end
    end

    assign mem_req      = (grant_inst && inst_req) || (grant_data && data_req);
    assign accept       = mem_req && mem_addr_ok;
    assign inst_addr_ok = accept && grant_inst;
    assign data_addr_ok = accept && grant_data;

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = '0;
        mem_wstrb = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_inst) begin
            mem_wr    = inst_wr;
            mem_size  = inst_size;
            mem_wstrb = inst_wstrb;
            mem_addr  = inst_addr;
            mem_wdata = inst_wdata;
        end else if (grant_data) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end
    end

    // A requester dropping req while locked sends us back to IDLE; while full the lock is kept
    always_comb begin
        state_d = state_q;
        if (accept)
            state_d = IDLE;
        else if (mem_req)
            state_d = grant_inst ? HOLD_INST : HOLD_DATA;
        else if (arb_en)
            state_d = IDLE;
    end

    assign head_tag     = tag_fifo[rd_ptr_q];
    assign pop          = mem_data_ok && !fifo_empty && !reset;
    assign inst_data_ok = pop && !head_tag;
    assign data_data_ok = pop && head_tag;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;
    assign outstanding  = count_q;
    assign protocol_err = protocol_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant_q <= grant_data;
                wr_ptr_q     <= wr_ptr_q + PTR_W'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(accept) - CNT_W'(pop);
            if (mem_data_ok && fifo_empty)
                protocol_err_q <= 1'b1;
        end
    end

    // Tag storage needs no reset: occupancy decides which entries are live
    always_ff @(posedge clk) begin
        if (accept)
            tag_fifo[wr_ptr_q] <= grant_data;
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter with hand-computed expectations (MAX_OUTSTANDING = 2).
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic [1:0]  outstanding;
    logic        protocol_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .outstanding(outstanding), .protocol_err(protocol_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0;
        inst_addr = 32'h0; inst_wdata = 32'h0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    initial begin
        // Reset state
        idle_inputs();
        reset = 1;
        tick();
        tick();
        #1;
        check("rst_outstanding", 32'(outstanding), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_perr", 32'(protocol_err), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 0);
        reset = 0;
        tick();

        // 1: single fetch
        inst_req = 1; inst_addr = 32'hbfc00000; mem_addr_ok = 1;
        #1;
        check("t1_inst_addr_ok", 32'(inst_addr_ok), 1);
        check("t1_mem_addr", mem_addr, 32'hbfc00000);
        check("t1_data_addr_ok", 32'(data_addr_ok), 0);
        tick();
        inst_req = 0; mem_addr_ok = 0;
        #1;
        check("t1_outstanding1", 32'(outstanding), 1);
        check("t1_no_req", 32'(mem_req), 0);
        tick();
        mem_data_ok = 1; mem_rdata = 32'h3c1d0001;
        #1;
        check("t1_inst_data_ok", 32'(inst_data_ok), 1);
        check("t1_data_data_ok", 32'(data_data_ok), 0);
        check("t1_inst_rdata", inst_rdata, 32'h3c1d0001);
        tick();
        mem_data_ok = 0;
        #1;
        check("t1_outstanding0", 32'(outstanding), 0);

        // 2: tie after reset, round-robin D,I,D with responses keeping the FIFO non-full
        apply_reset();
        inst_req = 1; inst_addr = 32'h1000; data_req = 1; data_addr = 32'h2000;
        data_wr = 1; mem_addr_ok = 1;
        #1;
        check("t2_c0_data_ok", 32'(data_addr_ok), 1);
        check("t2_c0_inst_ok", 32'(inst_addr_ok), 0);
        check("t2_c0_addr", mem_addr, 32'h2000);
        check("t2_c0_wr", 32'(mem_wr), 1);
        tick();
        mem_data_ok = 1;
        #1;
        check("t2_c1_inst_ok", 32'(inst_addr_ok), 1);
        check("t2_c1_addr", mem_addr, 32'h1000);
        check("t2_c1_resp_D", {30'd0, inst_data_ok, data_data_ok}, 32'b01);
        tick();
        #1;
        check("t2_c2_data_ok", 32'(data_addr_ok), 1);
        check("t2_c2_resp_I", {30'd0, inst_data_ok, data_data_ok}, 32'b10);
        tick();
        inst_req = 0; data_req = 0; data_wr = 0; mem_addr_ok = 0;
        #1;
        check("t2_c3_resp_D", {30'd0, inst_data_ok, data_data_ok}, 32'b01);
        tick();
        mem_data_ok = 0;
        #1;
        check("t2_outstanding0", 32'(outstanding), 0);

        // 3: grant lock while stalled
        apply_reset();
        inst_req = 1; inst_addr = 32'hbfc00010; data_addr = 32'h8000_0040;
        #1;
        check("t3_c0_addr", mem_addr, 32'hbfc00010);
        check("t3_c0_no_ok", 32'(inst_addr_ok), 0);
        tick();
        data_req = 1;
        #1;
        check("t3_c1_addr", mem_addr, 32'hbfc00010);
        check("t3_c1_data_ok", 32'(data_addr_ok), 0);
        tick();
        #1;
        check("t3_c2_addr", mem_addr, 32'hbfc00010);
        tick();
        mem_addr_ok = 1;
        #1;
        check("t3_c3_inst_ok", 32'(inst_addr_ok), 1);
        check("t3_c3_addr", mem_addr, 32'hbfc00010);
        tick();
        inst_req = 0;
        #1;
        check("t3_c4_data_ok", 32'(data_addr_ok), 1);
        check("t3_c4_addr", mem_addr, 32'h8000_0040);
        tick();

        // 4: full (I,D queued), no same-cycle bypass on pop
        data_req = 0; inst_req = 1; mem_addr_ok = 1;
        #1;
        check("t4_full_count", 32'(outstanding), 2);
        check("t4_full_no_req", 32'(mem_req), 0);
        check("t4_full_no_ok", 32'(inst_addr_ok), 0);
        tick();
        mem_data_ok = 1;
        #1;
        check("t4_pop_inst", 32'(inst_data_ok), 1);
        check("t4_no_bypass", 32'(mem_req), 0);
        tick();
        mem_data_ok = 0;
        #1;
        check("t4_after_req", 32'(mem_req), 1);
        check("t4_after_ok", 32'(inst_addr_ok), 1);
        tick();
        inst_req = 0; mem_addr_ok = 0;
        #1;
        check("t4_count2", 32'(outstanding), 2);

        // 5: simultaneous push/pop at occupancy 1
        apply_reset();
        inst_req = 1; mem_addr_ok = 1;
        tick();
        inst_req = 0; data_req = 1; mem_data_ok = 1;
        #1;
        check("t5_inst_data_ok", 32'(inst_data_ok), 1);
        check("t5_data_addr_ok", 32'(data_addr_ok), 1);
        check("t5_data_data_ok", 32'(data_data_ok), 0);
        tick();
        data_req = 0; mem_addr_ok = 0;
        #1;
        check("t5_count1", 32'(outstanding), 1);
        check("t5_next_data", {30'd0, inst_data_ok, data_data_ok}, 32'b01);
        tick();
        mem_data_ok = 0;
        #1;
        check("t5_count0", 32'(outstanding), 0);

        // 6: reset mid-flight, then a stray response
        inst_req = 1; mem_addr_ok = 1;
        tick();
        tick();
        inst_req = 0; mem_addr_ok = 0;
        #1;
        check("t6_count2", 32'(outstanding), 2);
        apply_reset();
        #1;
        check("t6_cleared", 32'(outstanding), 0);
        mem_data_ok = 1;
        #1;
        check("t6_no_data_ok", {30'd0, inst_data_ok, data_data_ok}, 0);
        check("t6_perr_before", 32'(protocol_err), 0);
        tick();
        mem_data_ok = 0;
        #1;
        check("t6_perr_set", 32'(protocol_err), 1);
        tick();
        tick();
        check("t6_perr_sticky", 32'(protocol_err), 1);
        apply_reset();
        #1;
        check("t6_perr_cleared", 32'(protocol_err), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
Shares one SRAM-like memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage).
- Arbitrates request/addr_ok handshakes and locks the grant until the address is accepted.
- Records the source of every accepted request in an in-order tag FIFO.
- Steers each returning data_ok/rdata to the requester that issued it.
- Sits between the CPU pipeline and the AXI bridge / memory-side SRAM-like slave.

Parameters:
MAX_OUTSTANDING, 2, depth of the source-tag FIFO (max accepted-but-unanswered requests); power of two, 2..8.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
inst_req  in  1  fetch request valid
inst_wr  in  1  fetch write flag (always 0 from IF, passed through)
inst_size  in  2  transfer size
inst_wstrb  in  4  byte strobes
inst_addr  in  32  fetch address
inst_wdata  in  32  write data
inst_addr_ok  out  1  fetch address accepted
inst_data_ok  out  1  fetch response valid
inst_rdata  out  32  fetch response data
data_req  in  1  data request valid
data_wr  in  1  1 = store
data_size  in  2  transfer size
data_wstrb  in  4  byte strobes
data_addr  in  32  data address
data_wdata  in  32  store data
data_addr_ok  out  1  data address accepted
data_data_ok  out  1  data response valid
data_rdata  out  32  data response data
mem_req  out  1  request to memory
mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/2/4/32/32  muxed payload of the granted requester
mem_addr_ok  in  1  memory accepted address
mem_data_ok  in  1  memory response valid
mem_rdata  in  32  memory response data
outstanding  out  $clog2(MAX_OUTSTANDING)+1  current FIFO occupancy
protocol_err  out  1  sticky: mem_data_ok received with FIFO empty

Behaviour:
Clock and reset:
- One clock, clk.
- reset is synchronous, active-high; all state clears on the clk edge with reset=1.

Reset state:
- FSM IDLE, FIFO empty, outstanding=0, last_grant=INST, protocol_err=0.
- All req/ok outputs 0; payload outputs 0.

FSM states:
- IDLE, HOLD_INST, HOLD_DATA.
- grant is combinational from state + requests.
- IDLE: candidates are requesters with req=1, only when FIFO not full.
  - One candidate: it wins.
  - Both: round-robin; the one not equal to last_grant wins (data wins the first tie after reset).
- HOLD_x: grant=x unconditionally, even if the other requester also requests.
- mem_req = granted requester's req, gated by FIFO-not-full.
- Payload is muxed from the granted requester; zeros when none is granted.

Accept (mem_req && mem_addr_ok):
- Granted requester's addr_ok=1 in the same cycle (combinational).
- Push tag (0=inst, 1=data); last_grant <= winner; next state IDLE.

Stall (mem_req && !mem_addr_ok):
- Next state HOLD_winner.
- In HOLD_x, if x drops req (protocol violation), return to IDLE with nothing pushed.

FIFO full (occupancy == MAX_OUTSTANDING):
- mem_req=0, no grant, no push.
- No same-cycle bypass, even when mem_data_ok pops that cycle.
- HOLD state is retained while full; it cannot be entered from full.

Response (mem_data_ok with FIFO non-empty):
- Pop head.
- Head=0 → inst_data_ok=1; head=1 → data_data_ok=1.
- Combinational, zero added latency.
- inst_rdata = data_rdata = mem_rdata at all times; only the ok signals are steered.

Simultaneous accept and response:
- Push and pop in the same cycle; occupancy unchanged.
- The response is routed from the old head.

Response with FIFO empty:
- No data_ok output, no pop.
- protocol_err <= 1 until reset.

Wrap-around:
- Read/write pointers wrap modulo MAX_OUTSTANDING.
- Occupancy counts 0..MAX_OUTSTANDING.

Reset mid-operation:
- Outstanding tags are discarded.
- Memory must not return data_ok for pre-reset requests; if it does, protocol_err is set.

Test Plan:
1. Single fetch: inst_req=1 addr=0xbfc00000, mem_addr_ok=1 same cycle → inst_addr_ok=1 that cycle, outstanding=1; mem_data_ok=1 rdata=0x3c1d0001 two cycles later → inst_data_ok=1, inst_rdata=0x3c1d0001, outstanding=0.
2. Tie after reset: inst_req=data_req=1, mem_addr_ok=1 every cycle → cycle0 data granted, cycle1 inst granted, cycle2 data; responses return tags in order D,I,D.
3. Grant lock: inst granted with mem_addr_ok=0 for 3 cycles while data_req rises in cycle1 → mem_addr stays inst_addr through cycle3; inst accepted cycle3; data granted cycle4.
4. Full: MAX_OUTSTANDING=2, two accepts with no responses, third inst_req=1 → mem_req=0; mem_data_ok in cycle N pops → mem_req=1 in cycle N+1 (no same-cycle bypass).
5. Simultaneous push/pop at occupancy 1 (tag I queued, data accepted while mem_data_ok=1) → inst_data_ok=1, data_addr_ok=1, outstanding stays 1, next response goes to data.
6. Reset with 2 outstanding, then mem_data_ok=1 → no data_ok on either side, protocol_err=1 and held until next reset.
